zoom_ctrl: RTL

Frame/line sequencer for the bilinear zoom datapath in the MTL photo-viewer pipeline. For each output line it drives the zoom engine's accumulator resets and 3-bit phase enable: shift, then horizontal load, then vertical output. It latches the zoom factor once per frame, stalls the horizontal phase while the source pixel FIFO is empty, and starts each output phase only when the display side requests a line.

---
 rtl/zoom_ctrl.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/zoom_ctrl.sv
// ---------------------------------------------------------------------------
// zoom_ctrl
//
// Frame/line sequencer for the bilinear zoom datapath. For every output line
// it resets the horizontal accumulator and then steps the zoom engine
// through three phases: buffer shift, horizontal load and vertical output.
// The zoom factor is captured once per frame. The horizontal phase can stall
// on an empty source FIFO. The output phase starts only after the display
// requests a line.
//
// Build option:
//   ZOOM_CTRL_FIFO_STALL_EN  defined   -> horizontal load is gated by iEMPTY
//                            undefined -> iEMPTY is ignored and the
//                                         horizontal phase is H_OUT cycles
//
// Parameters:
//   H_OUT  output pixels per line (cycle count of each phase)
//   V_OUT  output lines per frame
//
// Ports:
//   iCLK          clock
//   iRST          synchronous active-high reset
//   iFRAME_START  one-cycle pulse: start a frame, or restart the current one
//   iFACTOR[7:0]  requested step per output pixel (1/128 source pixel)
//   iEMPTY        source pixel FIFO empty
//   iLINE_REQ     display ready to accept one output line
//   oRSTN_HOR     active-low reset to the horizontal accumulator
//   oRSTN_VER     active-low reset to the vertical accumulator
//   oEN[2:0]      phase enable: [0] horizontal load, [1] shift, [2] output
//   oFACTOR[7:0]  factor captured for the current frame
//   oBUSY         frame in progress
//   oLINE_DONE    one-cycle pulse at the end of each output line
//   oFRAME_DONE   one-cycle pulse with the last line's oLINE_DONE
// ---------------------------------------------------------------------------
module zoom_ctrl #(
  parameter int H_OUT = 800,
  parameter int V_OUT = 480
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iFRAME_START,
  input  logic [7:0] iFACTOR,
  input  logic       iEMPTY,
  input  logic       iLINE_REQ,
  output logic       oRSTN_HOR,
  output logic       oRSTN_VER,
  output logic [2:0] oEN,
  output logic [7:0] oFACTOR,
  output logic       oBUSY,
  output logic       oLINE_DONE,
  output logic       oFRAME_DONE
);

  // Counters hold the full terminal value, so they never wrap.
  localparam int PW = $clog2(H_OUT + 1);
  localparam int LW = $clog2(V_OUT + 1);

  localparam logic [PW-1:0] PIX_LAST  = PW'(H_OUT);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_OUT);

  localparam logic [2:0] EN_OFF = 3'b000;
  localparam logic [2:0] EN_HOR = 3'b001;
  localparam logic [2:0] EN_SHF = 3'b010;
  localparam logic [2:0] EN_OUT = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRAME_INIT,
    S_LINE_INIT,
    S_SHIFT,
    S_HOR,
    S_WAIT_REQ,
    S_OUT,
    S_LINE_END
  } state_t;

  // Registered state and outputs
  state_t          r_state;
  logic [PW-1:0]   r_pix;
  logic [LW-1:0]   r_line;
  logic [2:0]      r_en;
  logic            r_rstn_hor;
  logic            r_rstn_ver;
  logic [7:0]      r_factor;
  logic            r_busy;
  logic            r_line_done;
  logic            r_frame_done;

  // Next-cycle values
  state_t          w_state_nxt;
  logic [PW-1:0]   w_pix_nxt;
  logic [LW-1:0]   w_line_nxt;
  logic [2:0]      w_en_nxt;
  logic            w_rstn_hor_nxt;
  logic            w_rstn_ver_nxt;
  logic [7:0]      w_factor_nxt;
  logic            w_line_done_nxt;
  logic            w_frame_done_nxt;
  logic [LW-1:0]   w_line_inc;

  // w_grant: a horizontal load may be issued this cycle.
  logic            w_grant;

`ifdef ZOOM_CTRL_FIFO_STALL_EN
  assign w_grant = !iEMPTY;
`else
  logic w_unused_empty;
  assign w_unused_empty = iEMPTY;
  assign w_grant        = 1'b1;
`endif

  assign w_line_inc = r_line + LW'(1);

  // -------------------------------------------------------------------------
  // Next state and next outputs.
  //
  // Every output is registered together with the state. The logic therefore
  // computes the values that become visible after the coming edge.
  // r_pix counts the enable cycles already issued in the current phase. In
  // HOR it counts only granted loads, so a stalled cycle does not consume a
  // pixel. A phase ends once r_pix has reached H_OUT.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_pix_nxt        = r_pix;
    w_line_nxt       = r_line;
    w_en_nxt         = EN_OFF;
    w_rstn_hor_nxt   = 1'b1;
    w_rstn_ver_nxt   = 1'b1;
    w_factor_nxt     = r_factor;
    w_line_done_nxt  = 1'b0;
    w_frame_done_nxt = 1'b0;

    if (iFRAME_START) begin
      // Start, or abort and restart. The current line produces no done pulses.
      w_state_nxt    = S_FRAME_INIT;
      w_rstn_ver_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end

        S_FRAME_INIT: begin
          // A zero step would freeze the accumulator, so promote it to 1.
          w_factor_nxt   = (iFACTOR == 8'd0) ? 8'd1 : iFACTOR;
          w_line_nxt     = '0;
          w_pix_nxt      = '0;
          w_rstn_hor_nxt = 1'b0;
          w_state_nxt    = S_LINE_INIT;
        end

        S_LINE_INIT: begin
          w_state_nxt = S_SHIFT;
          w_en_nxt    = EN_SHF;
          w_pix_nxt   = PW'(1);
        end

        S_SHIFT: begin
          if (r_pix == PIX_LAST) begin
            // The first horizontal load is issued on the same edge that
            // enters HOR.
            w_state_nxt = S_HOR;
            w_en_nxt    = w_grant ? EN_HOR : EN_OFF;
            w_pix_nxt   = w_grant ? PW'(1) : PW'(0);
          end else begin
            w_en_nxt  = EN_SHF;
            w_pix_nxt = r_pix + PW'(1);
          end
        end

        S_HOR: begin
          if (r_pix == PIX_LAST) begin
            w_state_nxt = S_WAIT_REQ;
          end else if (w_grant) begin
            w_en_nxt  = EN_HOR;
            w_pix_nxt = r_pix + PW'(1);
          end
        end

        S_WAIT_REQ: begin
          if (iLINE_REQ) begin
            w_state_nxt = S_OUT;
            w_en_nxt    = EN_OUT;
            w_pix_nxt   = PW'(1);
          end
        end

        S_OUT: begin
          if (r_pix == PIX_LAST) begin
            // The done pulses are visible during LINE_END itself.
            w_state_nxt      = S_LINE_END;
            w_line_done_nxt  = 1'b1;
            w_line_nxt       = w_line_inc;
            w_frame_done_nxt = (w_line_inc == LINE_LAST);
          end else begin
            w_en_nxt  = EN_OUT;
            w_pix_nxt = r_pix + PW'(1);
          end
        end

        S_LINE_END: begin
          if (r_line == LINE_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt    = S_LINE_INIT;
            w_rstn_hor_nxt = 1'b0;
            w_pix_nxt      = '0;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State and output registers. Reset wins over every input.
  // -------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state      <= S_IDLE;
      r_pix        <= '0;
      r_line       <= '0;
      r_en         <= EN_OFF;
      r_rstn_hor   <= 1'b0;
      r_rstn_ver   <= 1'b0;
      r_factor     <= 8'd128;
      r_busy       <= 1'b0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pix        <= w_pix_nxt;
      r_line       <= w_line_nxt;
      r_en         <= w_en_nxt;
      r_rstn_hor   <= w_rstn_hor_nxt;
      r_rstn_ver   <= w_rstn_ver_nxt;
      r_factor     <= w_factor_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_line_done  <= w_line_done_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign oRSTN_HOR   = r_rstn_hor;
  assign oRSTN_VER   = r_rstn_ver;
  assign oEN         = r_en;
  assign oFACTOR     = r_factor;
  assign oBUSY       = r_busy;
  assign oLINE_DONE  = r_line_done;
  assign oFRAME_DONE = r_frame_done;

endmodule
